// File: rtl/delay_line_ram.sv
// ============================================================================
// Module  : delay_line_ram
// Brief   : Run-time configurable complex-sample delay line on a RAM circular
//           buffer. Optional macro DELAY_ZERO_FILL_EN zeroes output during fill.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_line_ram #(
    parameter int MAX_DEPTH = 1024,
    parameter int WIDTH     = 16,
    parameter int DLY_W     = 11
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    di_en,
    input  logic signed [WIDTH-1:0] di_re,
    input  logic signed [WIDTH-1:0] di_im,
    input  logic [DLY_W-1:0]        delay,
    output logic                    do_en,
    output logic signed [WIDTH-1:0] do_re,
    output logic signed [WIDTH-1:0] do_im,
    output logic                    filled
);

    localparam int PTR_W = $clog2(MAX_DEPTH);
    localparam int CNT_W = $clog2(MAX_DEPTH + 1);

    logic [PTR_W-1:0]        wptr_q, wptr_d;
    logic [CNT_W-1:0]        fill_cnt_q, fill_cnt_d;
    logic [DLY_W-1:0]        dly_q, dly_d;
    logic                    do_en_q, do_en_d;
    logic signed [WIDTH-1:0] do_re_q, do_re_d;
    logic signed [WIDTH-1:0] do_im_q, do_im_d;

    logic [2*WIDTH-1:0]      mem [MAX_DEPTH];

    logic [DLY_W-1:0]        dly_clamp;
    logic [PTR_W:0]          dm1;
    logic [PTR_W:0]          rdiff;
    logic [PTR_W:0]          rwrap;
    logic [PTR_W-1:0]        raddr;
    logic [2*WIDTH-1:0]      rd_word;
    logic                    dly_change;
    logic                    filled_w;

    always_comb begin
        dly_clamp = delay;
        if (delay == '0) begin
            dly_clamp = DLY_W'(1);
        end else if (delay > DLY_W'(MAX_DEPTH)) begin
            dly_clamp = DLY_W'(MAX_DEPTH);
        end
    end

    // One extra bit holds the sign of the difference so non-power-of-two
    // depths wrap correctly by adding MAX_DEPTH back.
    always_comb begin
        dm1   = (PTR_W+1)'(dly_q - DLY_W'(1));
        rdiff = {1'b0, wptr_q} - dm1;
        rwrap = rdiff;
        if (rdiff[PTR_W]) begin
            rwrap = rdiff + (PTR_W+1)'(MAX_DEPTH);
        end
        raddr = rwrap[PTR_W-1:0];
    end

    assign filled_w   = (DLY_W'(fill_cnt_q) >= (dly_q - DLY_W'(1)));
    assign dly_change = (dly_clamp != dly_q);
    assign rd_word    = (dly_q == DLY_W'(1)) ? {di_re, di_im} : mem[raddr];

    always_comb begin
        wptr_d     = wptr_q;
        fill_cnt_d = fill_cnt_q;
        dly_d      = dly_q;
        do_en_d    = 1'b0;
        do_re_d    = do_re_q;
        do_im_d    = do_im_q;

        if (di_en) begin
            wptr_d = (wptr_q == PTR_W'(MAX_DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
        end

        if (dly_change) begin
            // A new delay restarts the fill; the sample on this edge is not counted.
            dly_d      = dly_clamp;
            fill_cnt_d = '0;
`ifdef DELAY_ZERO_FILL_EN
            do_re_d    = '0;
            do_im_d    = '0;
`endif
        end else if (di_en) begin
            if (fill_cnt_q != CNT_W'(MAX_DEPTH)) begin
                fill_cnt_d = fill_cnt_q + CNT_W'(1);
            end
            do_en_d = filled_w;
            do_re_d = rd_word[2*WIDTH-1:WIDTH];
            do_im_d = rd_word[WIDTH-1:0];
`ifdef DELAY_ZERO_FILL_EN
            if (!filled_w) begin
                do_re_d = '0;
                do_im_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q     <= '0;
            fill_cnt_q <= '0;
            dly_q      <= dly_clamp;
            do_en_q    <= 1'b0;
            do_re_q    <= '0;
            do_im_q    <= '0;
        end else begin
            wptr_q     <= wptr_d;
            fill_cnt_q <= fill_cnt_d;
            dly_q      <= dly_d;
            do_en_q    <= do_en_d;
            do_re_q    <= do_re_d;
            do_im_q    <= do_im_d;
        end
    end

    // Storage has no reset so it maps onto RAM primitives.
    always_ff @(posedge clock) begin
        if (!reset && di_en) begin
            mem[wptr_q] <= {di_re, di_im};
        end
    end

    assign do_en  = do_en_q;
    assign do_re  = do_re_q;
    assign do_im  = do_im_q;
    assign filled = filled_w;

endmodule

`default_nettype wire

// File: tb/tb_delay_line_ram.sv
// ============================================================================
// Module  : tb_delay_line_ram
// Brief   : Self-checking bench for delay_line_ram (history-indexed model,
//           scoreboard queue, table vectors and multi-cycle sequences).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_delay_line_ram;

    localparam int MAXD = 1024;
    localparam int W    = 16;
    localparam int DW   = 11;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                di_en = 1'b0;
    logic signed [W-1:0] di_re = '0;
    logic signed [W-1:0] di_im = '0;
    logic [DW-1:0]       delay = '0;
    logic                do_en;
    logic signed [W-1:0] do_re;
    logic signed [W-1:0] do_im;
    logic                filled;

    delay_line_ram #(.MAX_DEPTH(MAXD), .WIDTH(W), .DLY_W(DW)) dut (
        .clock (clock),
        .reset (reset),
        .di_en (di_en),
        .di_re (di_re),
        .di_im (di_im),
        .delay (delay),
        .do_en (do_en),
        .do_re (do_re),
        .do_im (do_im),
        .filled(filled)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic en;
        int   re;
        int   im;
        bit   known;
    } exp_t;

    typedef struct {
        logic en;
        int   re;
        int   dly;
        logic exp_en;
        int   exp_re;
        bit   chk_data;
    } vec_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: sample history indexed by accept count since flush.
    int   hist_re [4096];
    int   hist_im [4096];
    int   m_d, m_n, m_re, m_im;
    logic m_en;
    bit   m_known;
    bit   model_valid = 0;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input int re, input int im, input int dly, input logic rst);
        exp_t e;
        int   c;
        int   k;
        reset = rst;
        di_en = en;
        di_re = W'(re);
        di_im = W'(im);
        delay = DW'(dly);
        if (model_valid && !rst) chk("filled", filled, (m_n >= m_d - 1));
        c = (dly == 0) ? 1 : ((dly > MAXD) ? MAXD : dly);
        if (rst) begin
            m_d = c; m_n = 0; m_en = 0; m_re = 0; m_im = 0; m_known = 1;
        end else if (c != m_d) begin
            m_d = c; m_n = 0; m_en = 0;
`ifdef DELAY_ZERO_FILL_EN
            m_re = 0; m_im = 0; m_known = 1;
`endif
        end else if (en) begin
            hist_re[m_n] = re;
            hist_im[m_n] = im;
            k = m_n - m_d + 1;
            m_n++;
            if (k >= 0) begin
                m_en = 1; m_re = hist_re[k]; m_im = hist_im[k]; m_known = 1;
            end else begin
                m_en = 0;
`ifdef DELAY_ZERO_FILL_EN
                m_re = 0; m_im = 0; m_known = 1;
`else
                m_known = 0;
`endif
            end
        end else begin
            m_en = 0;
        end
        model_valid = 1;
        e.en = m_en; e.re = m_re; e.im = m_im; e.known = m_known;
        sbq.push_back(e);
        @(posedge clock);
        #1;
        e = sbq.pop_front();
        chk("do_en", do_en, e.en);
        if (e.known) begin
            chk("do_re", do_re, e.re);
            chk("do_im", do_im, e.im);
        end
    endtask

    vec_t tbl [16];
    int   first;
    int   cap_re, cap_im;

    initial begin
        // Gapped stream, delay 4 (rows 0-11); delay 1 then 0 (rows 12-15).
        tbl[0]  = '{1, 1, 4, 0, 0, 0};   tbl[1]  = '{0, 0, 4, 0, 0, 0};
        tbl[2]  = '{1, 2, 4, 0, 0, 0};   tbl[3]  = '{1, 3, 4, 0, 0, 0};
        tbl[4]  = '{0, 0, 4, 0, 0, 0};   tbl[5]  = '{0, 0, 4, 0, 0, 0};
        tbl[6]  = '{1, 4, 4, 1, 1, 1};   tbl[7]  = '{1, 5, 4, 1, 2, 1};
        tbl[8]  = '{1, 6, 4, 1, 3, 1};   tbl[9]  = '{0, 0, 4, 0, 3, 1};
        tbl[10] = '{1, 7, 4, 1, 4, 1};   tbl[11] = '{0, 0, 4, 0, 4, 1};
        tbl[12] = '{1, 10, 1, 1, 10, 1}; tbl[13] = '{1, 11, 0, 1, 11, 1};
        tbl[14] = '{1, 12, 0, 1, 12, 1}; tbl[15] = '{0, 0, 0, 0, 12, 1};

        repeat (2) @(posedge clock);
        #1;

        drive(0, 0, 0, 4, 1);
        chk("reset_do_en", do_en, 0);
        chk("reset_do_re", do_re, 0);
        chk("reset_do_im", do_im, 0);
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].en, tbl[i].re, -tbl[i].re, tbl[i].dly, 0);
            chk("tbl_en", do_en, tbl[i].exp_en);
            if (tbl[i].chk_data) begin
                chk("tbl_re", do_re, tbl[i].exp_re);
                chk("tbl_im", do_im, -tbl[i].exp_re);
            end
        end
        drive(0, 0, 0, 1, 1);
        for (int i = 12; i < 16; i++) begin
            drive(tbl[i].en, tbl[i].re, -tbl[i].re, tbl[i].dly, 0);
            chk("tbl_en", do_en, tbl[i].exp_en);
            if (tbl[i].chk_data) begin
                chk("tbl_re", do_re, tbl[i].exp_re);
                chk("tbl_im", do_im, -tbl[i].exp_re);
            end
        end

        // Impulse through delay 32: visible on cycle 32 (after drive index 31).
        drive(0, 0, 0, 32, 1);
        first = -1; cap_re = 0; cap_im = 0;
        for (int s = 0; s < 40; s++) begin
            drive(1, (s == 0) ? 100 : 0, (s == 0) ? -100 : 0, 32, 0);
            if (do_en === 1'b1 && first < 0) begin
                first = s; cap_re = do_re; cap_im = do_im;
            end
        end
        chk("impulse_first_en", first, 31);
        chk("impulse_re", cap_re, 100);
        chk("impulse_im", cap_im, -100);

        // Maximum delay across the write-pointer wrap.
        drive(0, 0, 0, MAXD, 1);
        for (int s = 0; s < 3000; s++) begin
            drive(1, s, -s, MAXD, 0);
        end
        chk("wrap_last_re", do_re, 2999 - (MAXD - 1));

        // Mid-stream change 8 -> 3.
        drive(0, 0, 0, 8, 1);
        for (int s = 0; s < 20; s++) drive(1, 200 + s, 300 + s, 8, 0);
        drive(1, 220, 320, 3, 0);
        chk("change_do_en", do_en, 0);
        first = -1; cap_re = 0;
        for (int s = 1; s <= 8; s++) begin
            drive(1, 220 + s, 320 + s, 3, 0);
            if (do_en === 1'b1 && first < 0) begin
                first = s; cap_re = do_re;
            end
        end
        chk("change_first_en", first, 3);
        chk("change_re", cap_re, 221);

        // Reset mid-stream with delay 16.
        drive(0, 0, 0, 16, 1);
        for (int s = 0; s < 25; s++) drive(1, 500 + s, -500 - s, 16, 0);
        drive(1, 999, 999, 16, 1);
        chk("midrst_do_en", do_en, 0);
        chk("midrst_do_re", do_re, 0);
        chk("midrst_do_im", do_im, 0);
        first = -1;
        for (int s = 0; s < 20; s++) begin
            drive(1, 600 + s, -600 - s, 16, 0);
            if (do_en === 1'b1 && first < 0) first = s;
        end
        chk("midrst_first_en", first, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
